// File: rtl/alu_serial_seq_if.sv
// alu_serial_seq_if: request/result handshake bundle for the bit-serial ALU sequencer
interface alu_serial_seq_if #(parameter int WIDTH = 8);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a, b;
  logic ready, busy, result_valid, result_ack;
  logic [WIDTH-1:0] result;
  logic negativo, zero, cout, overflow;
  modport master(output start, op, a, b, result_ack,
                 input ready, busy, result_valid, result, negativo, zero, cout, overflow);
  modport slave(input start, op, a, b, result_ack,
                output ready, busy, result_valid, result, negativo, zero, cout, overflow);
endinterface

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: LSB-first bit-serial add/sub/inc/dec sequencer with its own 1-bit full-adder slice
module alu_serial_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst_n,
  alu_serial_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sa, sb, result, word;
  logic [WIDTH-2:0] acc;
  logic [1:0] op_r;
  logic carry, y, sum, c_next, last;
  logic negativo, zero, cout, overflow;
  // INC feeds y=0 and DEC feeds y=1, which is exactly op_r[0]
  always_comb y = op_r == 2'b00 ? sb[0] : op_r == 2'b01 ? ~sb[0] : op_r[0];
  assign sum = sa[0] ^ y ^ carry;
  assign c_next = (sa[0] & y) | (sa[0] & carry) | (y & carry);
  assign word = {sum, acc};
  assign last = cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.start) state_nx = RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (state == DONE && bus.result_ack) state_nx = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      carry <= 1'b0;
      sa <= '0;
      sb <= '0;
      acc <= '0;
      op_r <= 2'b00;
      result <= '0;
      negativo <= 1'b0;
      zero <= 1'b0;
      cout <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sa <= bus.a;
      sb <= bus.b;
      op_r <= bus.op;
      carry <= bus.op == 2'b01 || bus.op == 2'b10;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      carry <= c_next;
      cnt <= cnt + 1'b1;
      acc <= word[WIDTH-1:1];
      if (last) begin
        result <= word;
        negativo <= sum;
        zero <= word == '0;
        cout <= c_next;
        overflow <= carry ^ c_next;
      end
    end
  assign bus.ready = state == IDLE;
  assign bus.busy = state == RUN;
  assign bus.result_valid = state == DONE;
  assign bus.result = result;
  assign bus.negativo = negativo;
  assign bus.zero = zero;
  assign bus.cout = cout;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed and randomized checks of alu_serial_seq against an arithmetic reference model
module tb_alu_serial_seq;
  localparam int W = 8;
  typedef struct packed {logic [W-1:0] r; logic n, z, c, v;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  alu_serial_seq_if #(.WIDTH(W)) bus();
  alu_serial_seq #(.WIDTH(W), .CNT_W(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua = int'(a), ub = int'(b), sa = int'($signed(a)), sb = int'($signed(b)), u, s;
    logic c;
    case (op)
      2'd0: begin u = ua + ub; s = sa + sb; c = u > 2**W - 1; end
      2'd1: begin u = ua - ub; s = sa - sb; c = ua >= ub; end
      2'd2: begin u = ua + 1; s = sa + 1; c = ua == 2**W - 1; end
      default: begin u = ua - 1; s = sa - 1; c = ua != 0; end
    endcase
    e.r = W'(u);
    e.n = e.r[W-1];
    e.z = e.r == '0;
    e.c = c;
    e.v = s > 2**(W-1) - 1 || s < -(2**(W-1));
    return e;
  endfunction
  function automatic exp_t observed();
    return {bus.result, bus.negativo, bus.zero, bus.cout, bus.overflow};
  endfunction
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.result_valid && lat < W + 10) begin
      @(negedge clk);
      lat++;
    end
  endtask
  // Starts an op, scrambles the operand inputs after accept, and waits for result_valid
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    wait_valid(lat);
  endtask
  task automatic ack();
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.ready, bus.busy, bus.result_valid} !== 3'b100 || observed() !== '0) begin
      n_fail++;
      $display("FAIL reset: rdy/busy/valid=%b out=%h, expected 100 and 0", {bus.ready, bus.busy, bus.result_valid}, observed());
    end
    rst_n = 1'b1;
  endtask
  task automatic test_directed();
    logic [1:0] ops[6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [W-1:0] as[6] = '{8'h7F, 8'h05, 8'h80, 8'hFF, 8'h00, 8'h80};
    logic [W-1:0] bs[6] = '{8'h01, 8'h05, 8'h01, 8'h5A, 8'hC3, 8'h11};
    exp_t ex[6] = '{{8'h80, 4'b1001}, {8'h00, 4'b0110}, {8'h7F, 4'b0011},
                    {8'h00, 4'b0110}, {8'hFF, 4'b1000}, {8'h7F, 4'b0011}};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], lat);
      n_chk++;
      if (lat !== W || observed() !== ex[i]) begin
        n_fail++;
        $display("FAIL directed[%0d]: lat=%0d out=%h, expected lat=%0d out=%h", i, lat, observed(), W, ex[i]);
      end
      ack();
      n_chk++;
      if (!bus.ready || bus.result_valid || observed() !== ex[i]) begin
        n_fail++;
        $display("FAIL after_ack[%0d]: ready=%b valid=%b out=%h, expected 1 0 %h", i, bus.ready, bus.result_valid, observed(), ex[i]);
      end
    end
  endtask
  task automatic test_ignore_start_and_hold();
    exp_t e = model(2'd0, 8'h33, 8'h44);
    int lat;
    @(negedge clk);
    bus.op = 2'd0;
    bus.a = 8'h33;
    bus.b = 8'h44;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.op = 2'd1;
    bus.a = 8'hF0;
    bus.b = 8'h0F;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(lat);
    n_chk++;
    if (lat !== W - 2 || observed() !== e) begin
      n_fail++;
      $display("FAIL ignore_start: lat=%0d out=%h, expected lat=%0d out=%h", lat, observed(), W - 2, e);
    end
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (!bus.result_valid || bus.ready || observed() !== e) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%b ready=%b out=%h, expected 1 0 %h", i, bus.result_valid, bus.ready, observed(), e);
      end
    end
    bus.start = 1'b0;
    ack();
  endtask
  task automatic test_back_to_back();
    exp_t e = model(2'd1, 8'h20, 8'h90);
    int lat;
    issue(2'd2, 8'h41, 8'h00, lat);
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    bus.op = 2'd1;
    bus.a = 8'h20;
    bus.b = 8'h90;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++;
    if (!bus.busy) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, expected 1", bus.busy);
    end
    wait_valid(lat);
    n_chk++;
    if (lat !== W || observed() !== e) begin
      n_fail++;
      $display("FAIL b2b_result: lat=%0d out=%h, expected lat=%0d out=%h", lat, observed(), W, e);
    end
    ack();
  endtask
  task automatic test_reset_mid_run();
    exp_t e = model(2'd0, 8'h10, 8'h20);
    int lat;
    @(negedge clk);
    bus.op = 2'd0;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if ({bus.ready, bus.busy, bus.result_valid} !== 3'b100 || observed() !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy/busy/valid=%b out=%h, expected 100 and 0", {bus.ready, bus.busy, bus.result_valid}, observed());
    end
    issue(2'd0, 8'h10, 8'h20, lat);
    n_chk++;
    if (lat !== W || observed() !== e || bus.result !== 8'h30) begin
      n_fail++;
      $display("FAIL post_reset_add: lat=%0d out=%h, expected lat=%0d out=%h", lat, observed(), W, e);
    end
    ack();
  endtask
  task automatic test_random();
    logic [1:0] op;
    logic [W-1:0] a, b;
    exp_t e;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      e = model(op, a, b);
      issue(op, a, b, lat);
      n_chk++;
      if (lat !== W || observed() !== e) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d out=%h, expected lat=%0d out=%h", i, op, a, b, lat, observed(), W, e);
      end
      ack();
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    bus.result_ack = 1'b0;
    test_reset();
    test_directed();
    test_ignore_start_and_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer that drives a 1-bit ALU slice for one operand word, one bit per clock, LSB first.
- Supported operations: add, subtract, increment, decrement.
- Registers the slice carry between bits, assembles the WIDTH-bit result, and derives the negativo/zero/cout/overflow flags.
- Sits between the register/control path (issues operations) and the ALU flag/result consumers; includes its own 1-bit full-adder slice so it is self-contained.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; accepted only while ready=1
- op  in  2  00 ADD (A+B), 01 SUB (A-B), 10 INC (A+1), 11 DEC (A-1); B ignored for INC/DEC
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN
- result_valid  out  1  high in DONE; result and flags stable while high
- result_ack  in  1  consumer acknowledge; used only in DONE
- result  out  WIDTH  assembled result
- negativo  out  1  result[WIDTH-1]
- zero  out  1  result == 0
- cout  out  1  carry out of MSB (SUB/DEC: 1 = no borrow)
- overflow  out  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, counter=0, carry=0, shift registers=0.
  - result=0, all flags=0, result_valid=0, busy=0, ready=1.
  - Reset wins over every other input.
- Datapath per bit i: operand bits x=a[i]; y depends on op:
  - ADD: y=b[i]
  - SUB: y=~b[i]
  - INC: y=0
  - DEC: y=1
- Initial carry-in: 1 for SUB and INC; 0 for ADD and DEC.
- Per bit: sum=x^y^c, c_next=majority(x,y,c); sum shifts into the result register from the MSB side.
- State IDLE:
  - ready=1.
  - start=1 at an edge: latch a, b (into shift registers), op, initial carry; counter=0; go to RUN.
- State RUN:
  - busy=1, ready=0.
  - Each edge processes one bit and increments counter.
  - On the edge processing bit WIDTH-1 (counter==WIDTH-1):
    - cout <= c_next
    - overflow <= c_in_msb ^ c_next (carry into MSB xor carry out)
    - result <= final word
    - zero <= (final word == 0)
    - negativo <= final MSB
    - go to DONE.
  - Latency: start accepted at edge k → result_valid=1 after edge k+WIDTH.
- State DONE:
  - result_valid=1; result and flags held.
  - result_ack=1 at an edge → IDLE (ready=1 after that edge).
  - Result and flags keep their values in IDLE until the next operation completes; only result_valid drops.
- Ignored inputs:
  - start while busy or result_valid is ignored; no queueing.
  - result_ack outside DONE is ignored.
  - a, b, op changes after accept have no effect.
- Reset mid-RUN or in DONE: abort immediately to reset values; no partial result is exposed.
- Back-to-back operation: minimum issue interval WIDTH+2 cycles (accept, WIDTH bits, ack); start in the cycle after ack is accepted.
- Arithmetic is modulo 2**WIDTH. Flags per op at WIDTH=8:
  - INC 0xFF: cout=1.
  - DEC 0x00: cout=0 (borrow).
  - SUB: cout=1 iff a>=b unsigned.

Test Plan:
- ADD a=0x7F b=0x01 → after 8 cycles result=0x80, negativo=1, zero=0, cout=0, overflow=1.
- SUB a=0x05 b=0x05 → result=0x00, zero=1, cout=1, overflow=0, negativo=0; SUB a=0x80 b=0x01 → 0x7F, overflow=1, cout=1.
- INC a=0xFF → 0x00, zero=1, cout=1, overflow=0; DEC a=0x00 → 0xFF, negativo=1, cout=0, overflow=0; DEC a=0x80 → 0x7F, overflow=1.
- Handshake:
  - Pulse start during RUN with different operands → ignored; first result unchanged.
  - Hold result_ack low 5 cycles → result_valid and outputs stay constant.
  - Ack then start next cycle → accepted.
- Reset: assert rst_n=0 at bit 3 of an ADD → next cycle ready=1, busy=0, result_valid=0, result=0, flags=0; a fresh ADD 0x10+0x20 → 0x30.
- Random sweep (1000 ops, random op/a/b) against a golden model, checking result, all four flags, and latency exactly WIDTH cycles from accept to result_valid.
